// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device transmitter. Sends one command byte to
//               the keyboard using the clock-inhibit / request-to-send
//               sequence. It shifts out 8 data bits LSB first, then odd
//               parity and stop, and finally checks the device acknowledge.
//               The pads are open-collector and are driven through
//               active-high pull-low enables.
// Ports       : clk, rst        - system clock, asynchronous active-high reset
//               din, wr         - command byte and one-cycle start strobe
//               busy, done, err - transfer status (err valid with done)
//               ps2clk_in       - asynchronous PS/2 clock pad level
//               ps2data_in      - asynchronous PS/2 data pad level
//               ps2clk_oe       - 1 = pull the PS/2 clock line low
//               ps2data_oe      - 1 = pull the PS/2 data line low
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3360,
    parameter int TIMEOUT_CYCLES = 560000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       wr,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);

    localparam int c_INH_W  = $clog2(INHIBIT_CYCLES + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_FILT_W = $clog2(FILTER_LEN + 1);

    localparam logic [c_INH_W-1:0]  c_INH_LAST  = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_INH_W-1:0]  c_INH_PEN   = c_INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_LEN - 1);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_INHIBIT  = 3'd1;
    localparam logic [2:0] c_S_XFER     = 3'd2;
    localparam logic [2:0] c_S_WAITIDLE = 3'd3;
    localparam logic [2:0] c_S_FINISH   = 3'd4;

    // Pad synchronizers, clock glitch filter and falling-edge detect
    logic                r_clk_s1, r_clk_s2;
    logic                r_dat_s1, r_dat_s2;
    logic                r_clk_filt, r_clk_filt_d;
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                r_fall;

    // Transmit state
    logic [2:0]         r_state;
    logic [9:0]         r_shift;
    logic [3:0]         r_nbit;
    logic [c_INH_W-1:0] r_icnt;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_busy, r_done, r_err;
    logic               r_clk_oe, r_dat_oe;

    // The filtered level only flips after FILTER_LEN consecutive
    // synchronized samples disagree with it; any agreeing sample restarts
    // the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
            r_fall       <= 1'b0;
        end else begin
            r_clk_s1 <= ps2clk_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2data_in;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_LAST) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
            r_clk_filt_d <= r_clk_filt;
            r_fall       <= r_clk_filt_d & ~r_clk_filt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_shift  <= '0;
            r_nbit   <= '0;
            r_icnt   <= '0;
            r_tmo    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
        end else begin
            case (r_state)
                // FINISH holds done for its single cycle. busy is already low
                // there, so a new wr is accepted exactly as in IDLE.
                c_S_IDLE, c_S_FINISH: begin
                    r_done   <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_clk_oe <= 1'b0;
                    if (wr) begin
                        r_shift  <= {1'b1, ~^din, din};
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_clk_oe <= 1'b1;
                        r_icnt   <= '0;
                        r_state  <= c_S_INHIBIT;
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end

                c_S_INHIBIT: begin
                    if (r_icnt == c_INH_LAST) begin
                        r_clk_oe <= 1'b0;
                        r_tmo    <= '0;
                        r_nbit   <= '0;
                        r_state  <= c_S_XFER;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                        // Registered output: set one count early so the start
                        // bit is on the line during the last inhibit cycle.
                        if (r_icnt == c_INH_PEN) begin
                            r_dat_oe <= 1'b1;
                        end
                    end
                end

                c_S_XFER: begin
                    if (r_tmo == c_TMO_LAST) begin
                        r_err    <= 1'b1;
                        r_dat_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= c_S_FINISH;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (r_fall) begin
                            if (r_nbit == 4'd10) begin
                                // Eleventh edge: the device acknowledges by
                                // holding data low.
                                if (!r_dat_s2) begin
                                    r_state <= c_S_WAITIDLE;
                                end else begin
                                    r_err   <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_state <= c_S_FINISH;
                                end
                            end else begin
                                r_dat_oe <= ~r_shift[0];
                                r_shift  <= {1'b0, r_shift[9:1]};
                                r_nbit   <= r_nbit + 1'b1;
                            end
                        end
                    end
                end

                c_S_WAITIDLE: begin
                    r_dat_oe <= 1'b0;
                    if (r_tmo == c_TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_S_FINISH;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (r_clk_filt && r_dat_s2) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_S_FINISH;
                        end
                    end
                end

                default: begin
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_state  <= c_S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign ps2clk_oe  = r_clk_oe;
    assign ps2data_oe = r_dat_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a simple PS/2
//               device model on open-collector lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH  = 3360;
    localparam int TMO  = 6000;
    localparam int HALF = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       wr  = 1'b0;
    logic       busy, done, err;
    logic       ps2clk_oe, ps2data_oe;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    wire        ps2clk_in  = dev_clk & ~ps2clk_oe;
    wire        ps2data_in = dev_data & ~ps2data_oe;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: main writes the request, the compare process owns the rest
    int m_w       = -100;
    int req_cnt   = 0;
    int seen_cnt  = 0;
    bit m_exp_err = 1'b0;
    bit m_active  = 1'b0;
    bit m_err_hold = 1'b0;
    bit in_inh;
    int n_done    = 0;
    int m_done_cyc = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .wr         (wr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Line levels seen by the device after edges 1..10: data LSB first,
    // odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // Per-cycle comparison against the transfer timeline
    always @(negedge clk) begin
        if (rst) begin
            m_active   = 1'b0;
            m_err_hold = 1'b0;
        end else begin
            if (req_cnt != seen_cnt) begin
                seen_cnt = req_cnt;
                m_active = 1'b1;
            end
            in_inh = m_active && (cyc > m_w) && (cyc <= m_w + INH);
            chk("clk_oe", int'(ps2clk_oe), int'(in_inh));
            if (in_inh) chk("data_oe_inhibit", int'(ps2data_oe), int'(cyc == m_w + INH));
            if (!m_active || cyc <= m_w) begin
                chk("busy_idle", int'(busy), 0);
                chk("done_idle", int'(done), 0);
                chk("err_hold", int'(err), int'(m_err_hold));
                if (!m_active) chk("data_oe_idle", int'(ps2data_oe), 0);
            end else if (done) begin
                chk("busy_at_done", int'(busy), 0);
                chk("err_at_done", int'(err), int'(m_exp_err));
                chk("data_oe_at_done", int'(ps2data_oe), 0);
                m_active   = 1'b0;
                m_err_hold = m_exp_err;
                m_done_cyc = cyc;
                n_done++;
            end else begin
                chk("busy_active", int'(busy), 1);
                chk("err_active", int'(err), 0);
            end
        end
    end

    task automatic do_wr(input logic [7:0] d, input bit exp_err, output int nd0);
        @(negedge clk);
        nd0       = n_done;
        din       = d;
        wr        = 1'b1;
        m_w       = cyc;
        m_exp_err = exp_err;
        req_cnt++;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic pulse_wr(input logic [7:0] d);
        @(negedge clk);
        din = d;
        wr  = 1'b1;
        @(negedge clk);
        wr  = 1'b0;
    endtask

    task automatic wait_done(input int nd0, input int lim);
        int k = 0;
        while (n_done == nd0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", n_done, nd0 + 1);
    endtask

    // Device: waits for clock release, then clocks nedges edges, sampling the
    // data line at each rising edge. ack selects the data level at edge 11.
    task automatic dev_xfer(input int nedges, input bit ack, output logic [9:0] frame);
        frame = '0;
        while (cyc < m_w + INH + 1) @(negedge clk);
        repeat (30) @(negedge clk);
        chk("start_bit", int'(ps2data_in), 0);
        for (int k = 1; k <= nedges; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) frame[k-1] = ps2data_in;
            repeat (HALF / 2) @(negedge clk);
            if (k == 10) dev_data = ack ? 1'b0 : 1'b1;
            if (k == 11) dev_data = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
    endtask

    initial begin
        logic [9:0] frame;
        int         nd0;
        int         n;

        repeat (5) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_clk_oe", int'(ps2clk_oe), 0);
        chk("rst_data_oe", int'(ps2data_oe), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 0xED with ACK
        do_wr(8'hED, 1'b0, nd0);
        dev_xfer(11, 1'b1, frame);
        wait_done(nd0, 2000);
        chk("frame_ED_literal", int'(frame), int'(10'h3ED));
        chk("frame_ED_model", int'(frame), int'(model_frame(8'hED)));
        chk("err_ED", int'(err), 0);

        // 0xFF: inhibit length measured directly
        do_wr(8'hFF, 1'b0, nd0);
        n = 0;
        while (ps2clk_oe && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_len", n, 3360);
        dev_xfer(11, 1'b1, frame);
        wait_done(nd0, 2000);
        chk("frame_FF_literal", int'(frame), int'(10'h3FF));

        // 0x00 with an ignored wr of 0xFF during inhibit
        do_wr(8'h00, 1'b0, nd0);
        repeat (100) @(negedge clk);
        pulse_wr(8'hFF);
        dev_xfer(11, 1'b1, frame);
        wait_done(nd0, 2000);
        chk("frame_00_literal", int'(frame), int'(10'h300));
        chk("frame_00_model", int'(frame), int'(model_frame(8'h00)));

        // 0x01: parity bit driven low
        do_wr(8'h01, 1'b0, nd0);
        dev_xfer(11, 1'b1, frame);
        wait_done(nd0, 2000);
        chk("frame_01_literal", int'(frame), int'(10'h201));

        // NACK
        do_wr(8'hA5, 1'b1, nd0);
        dev_xfer(11, 1'b0, frame);
        wait_done(nd0, 2000);
        chk("frame_A5_model", int'(frame), int'(model_frame(8'hA5)));
        repeat (50) @(negedge clk);
        chk("err_held_after_nack", int'(err), 1);

        // Timeout: device never clocks; a second wr mid-transfer is ignored
        do_wr(8'h3C, 1'b1, nd0);
        while (cyc < m_w + INH + 500) @(negedge clk);
        pulse_wr(8'h55);
        wait_done(nd0, TMO + 1000);
        chk("timeout_cycle", m_done_cyc, m_w + 3361 + 6000);
        chk("timeout_err", int'(err), 1);

        // Reset mid-transfer after edge 4
        do_wr(8'hF0, 1'b0, nd0);
        dev_xfer(3, 1'b1, frame);
        dev_clk = 1'b0;
        repeat (40) @(negedge clk);
        chk("pre_rst_data_oe", int'(ps2data_oe), 1);
        chk("pre_rst_busy", int'(busy), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_clk_oe", int'(ps2clk_oe), 0);
        chk("async_rst_data_oe", int'(ps2data_oe), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        dev_clk = 1'b1;
        repeat (50) @(negedge clk);
        chk("no_done_after_rst", n_done, nd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
